booth_digit_encoder: RTL and testbench
======================================

// Module: booth_digit_encoder
// PURPOSE
//  Serial radix-4 Booth recoder: the encoder end of the approximate partial-product path.
//  Accepts one signed multiplier operand and emits one Booth digit per handshake, LSB
//  digit first, as one-hot magnitude flags plus a sign flag. Downstream partial-product
//  LUT cells consume these flags.
//  Low-order digits can be forced to zero for low-power approximate operation.
// PARAMETERS
//  WIDTH          16  multiplier operand width; must be even and >= 4; N = WIDTH/2 digits
//  APPROX_DIGITS   0  digits with index < APPROX_DIGITS are emitted as zero (0..N)
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 reset; synchronous, active-high
//  in_valid   in   1                 operand offered
//  in_ready   out  1                 block can accept an operand
//  in_mult    in   WIDTH             signed (two's complement) multiplier operand
//  dig_valid  out  1                 digit outputs valid
//  dig_ready  in   1                 consumer accepts the digit
//  dig_zero   out  1                 digit = 0
//  dig_one    out  1                 |digit| = 1
//  dig_two    out  1                 |digit| = 2
//  dig_neg    out  1                 digit is negative; never 1 when dig_zero=1
//  dig_idx    out  clog2(N)          index k of the current digit (weight 4^k)
//  dig_last   out  1                 current digit is k = N-1
//  busy       out  1                 operand in progress (state RUN)
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset values: state=IDLE, in_ready=1, dig_valid=0, dig_zero=1, dig_one/two/neg=0,
//   dig_idx=0, dig_last=0, busy=0.
//  FSM IDLE:
//   - in_ready=1 and dig_valid=0.
//   - When in_valid=1, load sh[WIDTH:0] <= {in_mult,1'b0}, set idx <= 0, go to RUN.
//  FSM RUN:
//   - in_ready=0 and dig_valid=1. in_valid is ignored and no operand is captured.
//   - On dig_valid&dig_ready: sh <= arithmetic shift right by 2 and idx <= idx+1.
//     If idx==N-1, go to IDLE instead.
//  Latency: digit 0 is presented the cycle after operand acceptance. Under a ready=1
//   consumer, one operand takes N+1 cycles, including a one-cycle IDLE bubble.
//  Digit decode is combinational from the registered state. Triplet t = sh[2:0] =
//   {y[2k+1], y[2k], y[2k-1]}, with y[-1]=0:
//   - 000 and 111 -> zero
//   - 001 and 010 -> +1
//   - 011 -> +2
//   - 100 -> -2
//   - 101 and 110 -> -1
//   - dig_neg = t[2] & ~(t[1]&t[0]); exactly one of zero/one/two is high.
//  Approximation: when idx < APPROX_DIGITS, outputs are forced to zero=1, one/two/neg=0.
//   The digit is still emitted and handshaked. APPROX_DIGITS=0 gives exact recoding.
//  Sum over k of digit_k*4^k equals signed in_mult exactly when APPROX_DIGITS=0.
//  Backpressure: while dig_valid=1 and dig_ready=0, all dig_* outputs and internal
//   state hold unchanged.
//  Boundaries:
//   - Most negative operand: 100..0 encodes as top digit -2 with all other digits zero.
//   - Operand -1 encodes as digit 0 = -1 with all other digits zero.
//  Reset mid-operation: the operand is discarded. The block is in IDLE with reset outputs
//   on the next cycle. rst has priority over any handshake in the same cycle.
// TESTING
//  T1 reset: hold rst 2 cycles -> in_ready=1, dig_valid=0, busy=0, dig_zero=1.
//  T2 WIDTH=8, in_mult=8'h5A, dig_ready=1 -> digits k0..k3 = -2,-1,+2,+1; dig_last only
//     on k3. Sum = 90.
//  T3 WIDTH=8, in_mult=8'h80 -> digits 0,0,0,-2 (neg=1, two=1 on k3). Sum = -128.
//  T4 backpressure: in T2, drop dig_ready for 3 cycles at k1 -> outputs stay -1 and
//     dig_idx stays 1. Sequence resumes unchanged.
//  T5 APPROX_DIGITS=1, in_mult=8'h5A -> digits 0,-1,+2,+1. Asserting in_valid during
//     RUN is ignored (in_ready=0).
//  T6 assert rst after k1 accepted -> next cycle IDLE. Then in_mult=8'hFF -> digits
//     -1,0,0,0.

Source files
------------

// File: rtl/booth_digit_encoder.sv
// Serial radix-4 Booth recoder: takes one signed multiplier operand and hands out
// one Booth digit per handshake, LSB digit first, as one-hot magnitude plus sign.
module booth_digit_encoder #(
  parameter int WIDTH         = 16,
  parameter int APPROX_DIGITS = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_mult,
  output logic                           dig_valid,
  input  logic                           dig_ready,
  output logic                           dig_zero,
  output logic                           dig_one,
  output logic                           dig_two,
  output logic                           dig_neg,
  output logic [$clog2(WIDTH/2)-1:0]     dig_idx,
  output logic                           dig_last,
  output logic                           busy
);

  localparam int N    = WIDTH / 2;
  localparam int IDXW = $clog2(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [WIDTH:0]   sh_reg;
  logic [IDXW-1:0]  idx_reg;
  logic [N-1:0]     approx_vec;
  logic [2:0]       triplet;
  logic             run;
  logic             approx;
  logic             dec_zero;
  logic             dec_one;
  logic             dec_two;
  logic             dec_neg;

  // Per-digit approximation mask, fixed at elaboration.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_approx
      assign approx_vec[gi] = (gi < APPROX_DIGITS);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sh_reg    <= '0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sh_reg    <= {in_mult, 1'b0};
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (dig_ready) begin
            // Arithmetic shift keeps the sign bit feeding the upper triplets.
            sh_reg <= {sh_reg[WIDTH], sh_reg[WIDTH], sh_reg[WIDTH:2]};
            if (idx_reg == LAST_IDX) begin
              idx_reg   <= '0;
              state_reg <= IDLE;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign triplet = sh_reg[2:0];

  always_comb begin
    dec_zero = 1'b0;
    dec_one  = 1'b0;
    dec_two  = 1'b0;
    case (triplet)
      3'b000, 3'b111: dec_zero = 1'b1;
      3'b001, 3'b010,
      3'b101, 3'b110: dec_one  = 1'b1;
      3'b011, 3'b100: dec_two  = 1'b1;
      default:        dec_zero = 1'b1;
    endcase
    dec_neg = triplet[2] & ~(triplet[1] & triplet[0]);
  end

  assign run       = (state_reg == RUN);
  assign approx    = approx_vec[idx_reg];
  assign in_ready  = ~run;
  assign dig_valid = run;
  assign busy      = run;
  assign dig_idx   = idx_reg;
  assign dig_last  = run && (idx_reg == LAST_IDX);

  // Outside RUN, or for approximated digits, present a clean zero digit.
  assign dig_zero = (run && !approx) ? dec_zero : 1'b1;
  assign dig_one  = run && !approx && dec_one;
  assign dig_two  = run && !approx && dec_two;
  assign dig_neg  = run && !approx && dec_neg;

endmodule

// File: tb/tb_booth_digit_encoder.sv
// Bench for booth_digit_encoder: an exact and an APPROX_DIGITS=1 instance share stimulus.
module tb_booth_digit_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_mult;
  logic       dig_ready;

  logic       in_ready_a, dig_valid_a, dig_zero_a, dig_one_a, dig_two_a, dig_neg_a;
  logic       dig_last_a, busy_a;
  logic [1:0] dig_idx_a;
  logic       in_ready_b, dig_valid_b, dig_zero_b, dig_one_b, dig_two_b, dig_neg_b;
  logic       dig_last_b, busy_b;
  logic [1:0] dig_idx_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_digit_encoder #(.WIDTH(8), .APPROX_DIGITS(0)) u_exact (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_mult(in_mult),
    .dig_valid(dig_valid_a), .dig_ready(dig_ready), .dig_zero(dig_zero_a),
    .dig_one(dig_one_a), .dig_two(dig_two_a), .dig_neg(dig_neg_a),
    .dig_idx(dig_idx_a), .dig_last(dig_last_a), .busy(busy_a)
  );

  booth_digit_encoder #(.WIDTH(8), .APPROX_DIGITS(1)) u_approx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_mult(in_mult),
    .dig_valid(dig_valid_b), .dig_ready(dig_ready), .dig_zero(dig_zero_b),
    .dig_one(dig_one_b), .dig_two(dig_two_b), .dig_neg(dig_neg_b),
    .dig_idx(dig_idx_b), .dig_last(dig_last_b), .busy(busy_b)
  );

  typedef struct {
    logic [7:0] mult;
    int         d[4];
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Digit k of the radix-4 Booth recoding: -2*y[2k+1] + y[2k] + y[2k-1], y[-1]=0.
  function automatic int model_digit(input logic [7:0] m, input int k);
    int ym1;
    ym1 = (k == 0) ? 0 : int'(m[2*k-1]);
    return -2 * int'(m[2*k+1]) + int'(m[2*k]) + ym1;
  endfunction

  // Expected {zero, one, two, neg} flag pattern for a digit value.
  function automatic int exp_flags(input int d);
    int mag;
    mag = (d < 0) ? -d : d;
    return {29'd0, d == 0, mag == 1, mag == 2, d < 0};
  endfunction

  function automatic int flags_value(input logic z, input logic o, input logic t, input logic n);
    int mag;
    mag = o ? 1 : (t ? 2 : 0);
    return n ? -mag : mag;
  endfunction

  task automatic check_digit(input int k, input int exp_d[4]);
    int db;
    db = (k < 1) ? 0 : exp_d[k];
    check($sformatf("flags_a k%0d", k), {28'd0, dig_zero_a, dig_one_a, dig_two_a, dig_neg_a}, exp_flags(exp_d[k]));
    check($sformatf("flags_b k%0d", k), {28'd0, dig_zero_b, dig_one_b, dig_two_b, dig_neg_b}, exp_flags(db));
    check($sformatf("idx k%0d", k), int'(dig_idx_a), k);
    check($sformatf("last k%0d", k), int'(dig_last_a), int'(k == 3));
    check($sformatf("hs k%0d", k), {29'd0, dig_valid_a, in_ready_a, busy_a}, 3'b101);
  endtask

  // One operand through both instances; optional stall at digit stall_k.
  task automatic run_op(input logic [7:0] m, input int exp_d[4], input int stall_k,
                        input int stall_n, input bit hold_valid);
    int sum_a, sum_b, exp_b;
    sum_a = 0; sum_b = 0; exp_b = 0;
    check("ready_idle", int'(in_ready_a & in_ready_b), 1);
    in_valid  = 1'b1;
    in_mult   = m;
    dig_ready = 1'b1;
    step();
    if (hold_valid) in_mult = ~m;
    else            in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == stall_k) begin
        dig_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check_digit(k, exp_d);
          step();
        end
        dig_ready = 1'b1;
      end
      check_digit(k, exp_d);
      sum_a += flags_value(dig_zero_a, dig_one_a, dig_two_a, dig_neg_a) * (4 ** k);
      sum_b += flags_value(dig_zero_b, dig_one_b, dig_two_b, dig_neg_b) * (4 ** k);
      if (k >= 1) exp_b += exp_d[k] * (4 ** k);
      if (k == 3) in_valid = 1'b0;
      step();
    end
    check("bubble", {30'd0, dig_valid_a, in_ready_a}, 2'b01);
    check("sum_a", sum_a, int'($signed(m)));
    check("sum_b", sum_b, exp_b);
    $display("op mult=%02h sum_exact=%0d sum_approx=%0d", m, sum_a, sum_b);
  endtask

  int         rd[4];
  logic [7:0] rm;

  initial begin
    vecs[0].mult = 8'h5A; vecs[0].d = '{-2, -1,  2,  1};
    vecs[1].mult = 8'h80; vecs[1].d = '{ 0,  0,  0, -2};
    vecs[2].mult = 8'hFF; vecs[2].d = '{-1,  0,  0,  0};
    vecs[3].mult = 8'h00; vecs[3].d = '{ 0,  0,  0,  0};
    vecs[4].mult = 8'h7F; vecs[4].d = '{-1,  0,  0,  2};
    vecs[5].mult = 8'h01; vecs[5].d = '{ 1,  0,  0,  0};

    rst = 1'b1; in_valid = 1'b0; in_mult = '0; dig_ready = 1'b0;
    step(); step();
    check("rst_ready", int'(in_ready_a), 1);
    check("rst_valid", int'(dig_valid_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_flags", {28'd0, dig_zero_a, dig_one_a, dig_two_a, dig_neg_a}, 4'b1000);
    check("rst_idx_last", {29'd0, dig_idx_a, dig_last_a}, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_op(vecs[i].mult, vecs[i].d, -1, 0, 1'b0);

    // Backpressure at k1 for 3 cycles, then in_valid held high during RUN.
    run_op(8'h5A, vecs[0].d, 1, 3, 1'b0);
    run_op(8'h5A, vecs[0].d, -1, 0, 1'b1);

    // Reset after k1 accepted, with a live handshake in the same cycle.
    in_valid = 1'b1; in_mult = 8'h5A; dig_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("pre_rst_idx", int'(dig_idx_a), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", {29'd0, dig_valid_a, in_ready_a, busy_a}, 3'b010);
    check("mid_rst_flags", {28'd0, dig_zero_a, dig_one_a, dig_two_a, dig_neg_a}, 4'b1000);
    check("mid_rst_idx", int'(dig_idx_a), 0);
    $display("mid-op reset applied");
    run_op(8'hFF, vecs[2].d, -1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rm = 8'($urandom);
      for (int k = 0; k < 4; k++) rd[k] = model_digit(rm, k);
      run_op(rm, rd, int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
